// File: rtl/clock_seq_pkg.sv
// Shared state encoding, default timing parameters and counter-width helper
// for the clock sequencer.
package clock_seq_pkg;

  typedef enum logic [1:0] {
    DCM_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int RST_CYCLES_DEF    = 8;
  localparam int LOCK_TIMEOUT_DEF  = 4096;
  localparam int SETTLE_CYCLES_DEF = 256;
  localparam int TICK_DIV_DEF      = 80;

  // Counters hold 0..n-1, so $clog2(n) bits suffice; keep at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_sequencer_if.sv
// Lock input and sequencing outputs of the clock sequencer; master is the
// sequencer, slave is whatever consumes the resets/tick.
interface clock_sequencer_if;
  logic       LOCKED;
  logic       DCM_RST;
  logic       SYS_RST_N;
  logic       TICK_1US;
  logic       READY;
  logic [7:0] RETRY_CNT;
  logic [1:0] STATE;

  modport master (
    input  LOCKED,
    output DCM_RST, SYS_RST_N, TICK_1US, READY, RETRY_CNT, STATE
  );

  modport slave (
    output LOCKED,
    input  DCM_RST, SYS_RST_N, TICK_1US, READY, RETRY_CNT, STATE
  );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, cleared by the asynchronous reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= '0;
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/clock_sequencer.sv
// DCM bring-up sequencer: pulses DCM reset, waits for and qualifies LOCKED,
// then releases system reset and generates a 1 us tick. Optional lock-wait
// watchdog enabled by CLOCK_SEQ_WATCHDOG_EN.
module clock_sequencer
  import clock_seq_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int TICK_DIV      = TICK_DIV_DEF
) (
  input  logic               BOARD_CLOCK,
  input  logic               RST_N,
  clock_sequencer_if.master  bus
);

  localparam int RW = cnt_w(RST_CYCLES);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int TW = cnt_w(TICK_DIV);

  // Terminal values are compared against, never counted past, so no wrap.
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);

  logic lock_s;

  state_e        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    retry_q, retry_d;

`ifdef CLOCK_SEQ_WATCHDOG_EN
  localparam int LW = cnt_w(LOCK_TIMEOUT);
  localparam logic [LW-1:0] TO_LAST = LW'(LOCK_TIMEOUT - 1);
  logic [LW-1:0] to_q, to_d;
`endif

  sync_2ff u_sync (
    .clk_i  (BOARD_CLOCK),
    .rst_ni (RST_N),
    .d_i    (bus.LOCKED),
    .q_o    (lock_s)
  );

  always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= DCM_RESET;
      rst_cnt_q <= '0;
      settle_q  <= '0;
      tick_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      settle_q  <= settle_d;
      tick_q    <= tick_d;
      retry_q   <= retry_d;
    end
  end

`ifdef CLOCK_SEQ_WATCHDOG_EN
  always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
    if (!RST_N) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  // Every counter defaults to zero, so leaving its state clears it.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = '0;
    settle_d  = '0;
    tick_d    = '0;
    retry_d   = retry_q;
`ifdef CLOCK_SEQ_WATCHDOG_EN
    to_d      = '0;
`endif
    unique case (state_q)
      DCM_RESET: begin
        if (rst_cnt_q == RST_LAST) state_d = WAIT_LOCK;
        else                       rst_cnt_d = rst_cnt_q + RW'(1);
      end
      WAIT_LOCK: begin
        if (lock_s) state_d = SETTLE;
`ifdef CLOCK_SEQ_WATCHDOG_EN
        else if (to_q == TO_LAST) state_d = DCM_RESET;
        else                      to_d = to_q + LW'(1);
`endif
      end
      SETTLE: begin
        if (!lock_s)                    state_d = DCM_RESET;
        else if (settle_q == SETTLE_LAST) state_d = RUN;
        else                            settle_d = settle_q + SW'(1);
      end
      RUN: begin
        if (!lock_s)                 state_d = DCM_RESET;
        else if (tick_q != TICK_LAST) tick_d = tick_q + TW'(1);
      end
      default: state_d = DCM_RESET;
    endcase

    // Reset itself is not an entry; only transitions from another state count.
    if (state_d == DCM_RESET && state_q != DCM_RESET && retry_q != 8'hFF)
      retry_d = retry_q + 8'd1;
  end

  assign bus.DCM_RST   = (state_q == DCM_RESET);
  assign bus.SYS_RST_N = (state_q == RUN);
  assign bus.READY     = (state_q == RUN);
  assign bus.TICK_1US  = (state_q == RUN) && (tick_q == TICK_LAST);
  assign bus.RETRY_CNT = retry_q;
  assign bus.STATE     = state_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer: vector table for the basic bring-up,
// then hand sequences for watchdog/idle wait, timing, glitches and saturation.
`timescale 1ns/1ps
module tb_clock_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_sequencer_if bus ();

  clock_sequencer dut (
    .BOARD_CLOCK (clk),
    .RST_N       (rst_n),
    .bus         (bus)
  );

  int nvec  = 0;
  int nfail = 0;

  // {STATE[1:0], DCM_RST, SYS_RST_N, READY, TICK_1US, RETRY_CNT[7:0]}
  typedef struct {
    logic        rst_n;
    logic        lock;
    int          n;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic r, input logic l, input int n,
                              input logic [1:0] st, input logic d, input logic s,
                              input logic rd, input logic tk, input logic [7:0] rc);
    vec_t v;
    v.rst_n = r; v.lock = l; v.n = n;
    v.exp = {st, d, s, rd, tk, rc};
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {bus.STATE, bus.DCM_RST, bus.SYS_RST_N, bus.READY, bus.TICK_1US, bus.RETRY_CNT};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    nvec++;
    if (act < lo || act > hi) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Counts consecutive samples (from the current one) where DCM_RST == v.
  task automatic dcm_run(input logic v, input int bound, output int n);
    n = 0;
    while (bus.DCM_RST === v && n < bound) begin
      n++;
      step(1);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, output bit ok);
    int n;
    n = 0;
    while (bus.STATE !== s && n < bound) begin
      step(1);
      n++;
    end
    ok = (bus.STATE === s);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n, bad, base, exp_rc;
    bit  ok, seen;

    // Entry 5 -> 6 -> 7: SETTLE entered 3 edges after LOCKED, RUN 256 edges later.
    tbl[0]  = mk(1'b0, 1'b0,   3, 2'd0, 1, 0, 0, 0, 8'd0);
    tbl[1]  = mk(1'b1, 1'b0,   7, 2'd0, 1, 0, 0, 0, 8'd0);
    tbl[2]  = mk(1'b1, 1'b0,   1, 2'd1, 0, 0, 0, 0, 8'd0);
    tbl[3]  = mk(1'b1, 1'b0, 100, 2'd1, 0, 0, 0, 0, 8'd0);
    tbl[4]  = mk(1'b1, 1'b1,   2, 2'd1, 0, 0, 0, 0, 8'd0);
    tbl[5]  = mk(1'b1, 1'b1,   1, 2'd2, 0, 0, 0, 0, 8'd0);
    tbl[6]  = mk(1'b1, 1'b1, 255, 2'd2, 0, 0, 0, 0, 8'd0);
    tbl[7]  = mk(1'b1, 1'b1,   1, 2'd3, 0, 1, 1, 0, 8'd0);
    tbl[8]  = mk(1'b1, 1'b1,  78, 2'd3, 0, 1, 1, 0, 8'd0);
    tbl[9]  = mk(1'b1, 1'b1,   1, 2'd3, 0, 1, 1, 1, 8'd0);
    tbl[10] = mk(1'b1, 1'b1,   1, 2'd3, 0, 1, 1, 0, 8'd0);
    tbl[11] = mk(1'b1, 1'b0,   2, 2'd3, 0, 1, 1, 0, 8'd0);
    tbl[12] = mk(1'b1, 1'b0,   1, 2'd0, 1, 0, 0, 0, 8'd1);
    tbl[13] = mk(1'b1, 1'b0,   7, 2'd0, 1, 0, 0, 0, 8'd1);
    tbl[14] = mk(1'b1, 1'b0,   1, 2'd1, 0, 0, 0, 0, 8'd1);

    bus.LOCKED = 1'b0;
    step(1);
    for (int i = 0; i < 15; i++) begin
      rst_n      = tbl[i].rst_n;
      bus.LOCKED = tbl[i].lock;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), {18'd0, outs()}, {18'd0, tbl[i].exp});
    end

    // Fresh reset, then lock never arrives.
    rst_n = 1'b0;
    bus.LOCKED = 1'b0;
    step(2);
    chk("reset_vals", {18'd0, outs()}, {18'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    rst_n = 1'b1;
`ifdef CLOCK_SEQ_WATCHDOG_EN
    dcm_run(1'b1, 100, n);
    chk("wd_rst_pulse1", n, 8);
    dcm_run(1'b0, 5000, n);
    chk("wd_wait_len", n, 4096);
    chk("wd_retry", bus.RETRY_CNT, 8'd1);
    dcm_run(1'b1, 100, n);
    chk("wd_rst_pulse2", n, 8);
`else
    step(8);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1);
      if (bus.STATE !== 2'd1 || bus.RETRY_CNT !== 8'd0 || bus.DCM_RST !== 1'b0) bad++;
    end
    chk("idle_wait_bad_cycles", bad, 0);
    chk("idle_state", bus.STATE, 2'd1);
    chk("idle_retry", bus.RETRY_CNT, 8'd0);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    dcm_run(1'b1, 100, n);
    chk("rst_pulse_after_reset", n, 8);
`endif

    // LOCKED 20 cycles after DCM_RST falls: release after sync + settle.
    step(20);
    bus.LOCKED = 1'b1;
    n = 0;
    while (bus.SYS_RST_N !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    chk_rng("release_latency", n, 257, 259);
    chk("ready_in_run", bus.READY, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        step(1);
        n++;
      end while (bus.TICK_1US !== 1'b1 && n < 200);
      if (k == 0) chk_rng("first_tick_gap", n, 79, 80);
      else        chk($sformatf("tick_period%0d", k), n, 80);
    end

    // Lock loss in RUN at tick counter 40.
    step(41);
    base = bus.RETRY_CNT;
    bus.LOCKED = 1'b0;
    n = 0; seen = 0;
    do begin
      step(1);
      n++;
      if (bus.TICK_1US === 1'b1) seen = 1;
    end while (bus.SYS_RST_N !== 1'b0 && n < 10);
    chk_rng("run_loss_fall", n, 1, 3);
    chk("run_loss_ready", bus.READY, 1'b0);
    chk("run_loss_no_tick", seen, 1'b0);
    dcm_run(1'b1, 100, n);
    chk("run_loss_dcm_pulse", n, 8);
    chk("run_loss_retry", bus.RETRY_CNT, base + 1);

    // One-cycle LOCKED glitch at settle count 100.
    base = bus.RETRY_CNT;
    bus.LOCKED = 1'b1;
    wait_state(2'd2, 20, ok);
    chk("glitch_enter_settle", ok, 1'b1);
    step(100);
    bus.LOCKED = 1'b0;
    step(1);
    bus.LOCKED = 1'b1;
    n = 0; seen = 0;
    while (bus.STATE !== 2'd0 && n < 10) begin
      if (bus.SYS_RST_N !== 1'b0) seen = 1;
      step(1);
      n++;
    end
    chk("glitch_back_to_reset", bus.STATE, 2'd0);
    chk("glitch_no_release", seen | bus.SYS_RST_N, 1'b0);
    chk("glitch_retry", bus.RETRY_CNT, base + 1);

    // 300 forced retries: counter saturates.
    base = bus.RETRY_CNT;
    ok = 1;
    for (int r = 0; r < 300 && ok; r++) begin
      wait_state(2'd2, 50, ok);
      if (ok) begin
        bus.LOCKED = 1'b0;
        wait_state(2'd0, 10, ok);
        bus.LOCKED = 1'b1;
      end
    end
    chk("retry_loop_done", ok, 1'b1);
    exp_rc = (base + 300 > 255) ? 255 : base + 300;
    chk("retry_saturated", bus.RETRY_CNT, exp_rc);
    wait_state(2'd3, 400, ok);
    chk("run_after_retries", ok, 1'b1);

    // Asynchronous reset mid-cycle while in RUN.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_vals", {18'd0, outs()}, {18'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    step(2);
    rst_n = 1'b1;
    dcm_run(1'b1, 100, n);
    chk("post_reset_dcm_pulse", n, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
